// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports plus the single-port memory side.
// slave = arbiter view, master = requesters and memory together.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            req;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic [1:0]            ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
        output ack, rdata, err, mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  ack, rdata, err, mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter/sequencer for a single-port data memory (IDLE -> ACCESS -> RESP).
// Optional address/alignment fault check is compiled in with `define DMEM_ARB_BOUNDS_CHK_EN.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 4096
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]            state;
    logic                  last_grant;
    logic                  cmd_id;
    logic                  cmd_we;
    logic                  cmd_fault;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  sel_id;
    logic                  sel_we;
    logic                  sel_fault;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  access_ok;

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch can be inferred.
        sel_id = bus.req[1];
        if (bus.req == 2'b11) begin
            sel_id = ~last_grant;
        end
        sel_addr  = sel_id ? bus.addr1  : bus.addr0;
        sel_wdata = sel_id ? bus.wdata1 : bus.wdata0;
        sel_we    = bus.we[sel_id];
    end

`ifdef DMEM_ARB_BOUNDS_CHK_EN
    localparam int unsigned MEM_BYTES = MEM_WORDS * 4;
    assign sel_fault = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_WIDTH'(MEM_BYTES));
`else
    assign sel_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cmd_id     <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_fault  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        cmd_id     <= sel_id;
                        cmd_we     <= sel_we;
                        cmd_fault  <= sel_fault;
                        cmd_addr   <= sel_addr;
                        cmd_wdata  <= sel_wdata;
                        last_grant <= sel_id;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Stores and faulted commands return zero data.
                    rdata_q <= (cmd_we || cmd_fault) ? '0 : bus.mem_read_data;
                    err_q   <= cmd_fault;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are gated by rst_n directly so a reset landing on ACCESS aborts the store.
    assign access_ok          = rst_n && (state == ACCESS) && !cmd_fault;
    assign bus.mem_read       = access_ok && !cmd_we;
    assign bus.mem_write      = access_ok && cmd_we;
    assign bus.mem_address    = cmd_addr;
    assign bus.mem_write_data = cmd_wdata;
    assign bus.ack            = (state == RESP) ? (cmd_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rdata          = rdata_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model (round-robin rule, word-array memory image).
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(4096)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, store committed at the clock edge.
    logic [31:0] mem_array [0:4095];
    assign bus.mem_read_data = mem_array[bus.mem_address[13:2]];
    always @(posedge clk) begin
        if (bus.mem_write) mem_array[bus.mem_address[13:2]] <= bus.mem_write_data;
    end

    // Reference model: expected memory image and the requester served last.
    logic [31:0] ref_mem [0:4095];
    int          model_last;

    // Wait for one transaction's ack, watching the memory strobes on the way.
    task automatic serve(input int who, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic exp_err, input int exp_lat,
                         input logic [1:0] drop, input string tag);
        int          cyc;
        int          n_acc;
        int          acc_cyc;
        logic        got;
        logic [1:0]  exp_ack;
        logic [31:0] exp_rdata;
        exp_ack   = (who == 1) ? 2'b10 : 2'b01;
        exp_rdata = (exp_err || exp_we) ? 32'h0 : ref_mem[exp_addr[13:2]];
        got = 1'b0; cyc = 0; n_acc = 0; acc_cyc = -1;
        while (!got && cyc < exp_lat + 4) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_read || bus.mem_write) begin
                n_acc++;
                acc_cyc = cyc;
                total++;
                if (bus.mem_write !== exp_we || bus.mem_read !== !exp_we || bus.mem_address !== exp_addr
                    || (exp_we && bus.mem_write_data !== exp_wdata)) begin
                    bad++;
                    $display("FAIL %s access: rd=%b wr=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                             tag, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data,
                             exp_we, exp_addr, exp_wdata);
                end
            end
            if (bus.ack !== 2'b00) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s ack timeout: no ack within %0d cycles, want ack=%b", tag, cyc, exp_ack);
        end else if (bus.ack !== exp_ack || cyc != exp_lat || bus.rdata !== exp_rdata || bus.err !== exp_err) begin
            bad++;
            $display("FAIL %s response: ack=%b lat=%0d rdata=%h err=%b, want ack=%b lat=%0d rdata=%h err=%b",
                     tag, bus.ack, cyc, bus.rdata, bus.err, exp_ack, exp_lat, exp_rdata, exp_err);
        end
        total++;
        if (n_acc != (exp_err ? 0 : 1) || (!exp_err && acc_cyc != exp_lat - 1)) begin
            bad++;
            $display("FAIL %s access count: got %0d at cycle %0d, want %0d at cycle %0d",
                     tag, n_acc, acc_cyc, exp_err ? 0 : 1, exp_lat - 1);
        end
        bus.req = bus.req & ~drop;
        model_last = who;
        if (!exp_err && exp_we) ref_mem[exp_addr[13:2]] = exp_wdata;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        model_last = 1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.req    = 2'b11;
        bus.we     = 2'b11;
        bus.addr0  = 32'h40;
        bus.addr1  = 32'h80;
        bus.wdata0 = 32'h1111_1111;
        bus.wdata1 = 32'h2222_2222;
        repeat (3) @(negedge clk);
        total++;
        if (bus.ack !== 2'b00 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes: ack=%b rd=%b wr=%b, want 00 0 0", bus.ack, bus.mem_read, bus.mem_write);
        end
        bus.req = 2'b00;
        rst_n   = 1'b1;
        model_last = 1;
        @(negedge clk);
        total++;
        if (bus.rdata !== 32'h0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_resp: rdata=%h err=%b, want 0 0", bus.rdata, bus.err);
        end
        total++;
        if (bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_cmd: addr=%h wdata=%h, want 0 0", bus.mem_address, bus.mem_write_data);
        end
    endtask

    task automatic test_store_load();
        bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 32'h10; bus.wdata0 = 32'hDEAD_BEEF;
        serve(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 2, 2'b01, "store0");
        @(negedge clk);
        total++;
        if (mem_array[4] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL store0_mem: word4=%h, want deadbeef", mem_array[4]);
        end
        bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 32'h10;
        serve(1, 1'b0, 32'h10, 32'h0, 1'b0, 2, 2'b10, "load1");
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [31:0] a [2];
        apply_reset();
        a[0] = {18'b0, 12'($urandom), 2'b00};
        a[1] = {18'b0, 12'($urandom), 2'b00};
        bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = a[0]; bus.addr1 = a[1];
        for (int k = 0; k < 4; k++) begin
            int who;
            who = (model_last == 0) ? 1 : 0;
            serve(who, 1'b0, a[who], 32'h0, 1'b0, (k == 0) ? 2 : 3, (k == 3) ? 2'b11 : 2'b00, "rr");
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int acks;
        bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 32'h20; bus.wdata0 = 32'h1234_5678;
        @(negedge clk);
        total++;
        if (bus.mem_write !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre: wr=%b, want 1", bus.mem_write);
        end
        rst_n   = 1'b0;
        bus.req = 2'b00;
        #1;
        total++;
        if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
            bad++;
            $display("FAIL abort_gate: wr=%b rd=%b, want 0 0", bus.mem_write, bus.mem_read);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ack !== 2'b00) acks++;
        end
        total++;
        if (acks != 0 || mem_array[8] !== ref_mem[8] || bus.mem_address !== 32'h0) begin
            bad++;
            $display("FAIL abort_after: acks=%0d word8=%h addr=%h, want 0 %h 0", acks, mem_array[8], ref_mem[8], bus.mem_address);
        end
        bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 32'h20;
        serve(1, 1'b0, 32'h20, 32'h0, 1'b0, 2, 2'b10, "abort_follow");
        @(negedge clk);
    endtask

    task automatic test_bounds();
`ifdef DMEM_ARB_BOUNDS_CHK_EN
        logic [31:0] w;
        w = $urandom;
        bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 32'h4000; bus.wdata0 = w;
        serve(0, 1'b1, 32'h4000, w, 1'b1, 2, 2'b01, "oob_store");
        @(negedge clk);
        bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 32'h6;
        serve(1, 1'b0, 32'h6, 32'h0, 1'b1, 2, 2'b10, "misaligned_load");
`else
        bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 32'h6;
        serve(1, 1'b0, 32'h6, 32'h0, 1'b0, 2, 2'b10, "unchecked_load");
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        a = {18'b0, 12'($urandom), 2'b00};
        bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = a;
        serve(0, 1'b0, a, 32'h0, 1'b0, 2, 2'b00, "b2b_first");
        serve(0, 1'b0, a, 32'h0, 1'b0, 3, 2'b01, "b2b_second");
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [1:0]  r;
            logic [31:0] a [2];
            logic [31:0] w [2];
            logic [1:0]  wem;
            int          first;
            r    = 2'($urandom_range(1, 3));
            wem  = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                a[i] = {18'b0, 12'($urandom_range(0, 15)), 2'b00};
                w[i] = $urandom;
            end
            bus.req = r; bus.we = wem;
            bus.addr0 = a[0]; bus.addr1 = a[1]; bus.wdata0 = w[0]; bus.wdata1 = w[1];
            if (r == 2'b11) first = (model_last == 0) ? 1 : 0;
            else            first = r[1] ? 1 : 0;
            serve(first, wem[first], a[first], w[first], 1'b0, 2, (first == 1) ? 2'b10 : 2'b01, "rand_a");
            if (r == 2'b11) begin
                int second;
                second = 1 - first;
                serve(second, wem[second], a[second], w[second], 1'b0, 3, (second == 1) ? 2'b10 : 2'b01, "rand_b");
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_array[i] = 32'h0;
            ref_mem[i]   = 32'h0;
        end
        rst_n      = 1'b0;
        bus.req    = 2'b00;
        bus.we     = 2'b00;
        bus.addr0  = 32'h0;
        bus.addr1  = 32'h0;
        bus.wdata0 = 32'h0;
        bus.wdata1 = 32'h0;
        model_last = 1;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_round_robin();
        test_abort();
        test_bounds();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory.
- Shares the memory between requester 0 (CPU load/store path) and requester 1 (DMA/debug loader).
- Uses round-robin priority and a req/ack handshake.
- Registers each command, issues exactly one memory access, and returns the registered read data with a one-cycle ack pulse.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the requester and memory address buses.
- DATA_WIDTH, 32, data word width.
- MEM_WORDS, 4096, memory depth in words; used only by the optional bounds check.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  2  per-requester request; bit i belongs to requester i.
- we  input  2  per-requester write enable (1 = store, 0 = load).
- addr0, addr1  input  ADDR_WIDTH  byte address of each requester.
- wdata0, wdata1  input  DATA_WIDTH  store data of each requester.
- ack  output  2  one-cycle completion pulse per requester.
- rdata  output  DATA_WIDTH  load result; valid only while the relevant ack bit is high.
- err  output  1  access fault; valid with ack; only active when the optional feature is compiled in.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_address  output  ADDR_WIDTH  memory byte address.
- mem_write_data  output  DATA_WIDTH  memory write data.
- mem_read_data  input  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE and last_grant goes to 1, so requester 0 wins the first tie.
  - ack, rdata, err and the command registers go to 0, so mem_address and mem_write_data read 0.
- mem_read and mem_write are gated combinationally by rst_n. A store in its ACCESS cycle is suppressed if rst_n is low at that edge. No ack is issued for an aborted transaction.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req bit is high, select a winner:
    - a single requester wins directly;
    - if both request, the winner is the one not equal to last_grant.
  - Latch the winner's addr, wdata and we, plus the winner id, into the command registers; update last_grant; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_address and mem_write_data come from the command registers.
  - mem_write = cmd_we. The memory commits the store at the end of this cycle.
  - mem_read = not cmd_we.
  - On a load, rdata captures mem_read_data at the end of the cycle; on a store, rdata captures 0.
  - Go to RESP.
- RESP:
  - ack[winner] = 1 for exactly this cycle; the other ack bit stays 0.
  - Go to IDLE.
- Outside ACCESS, mem_read = mem_write = 0. mem_address and mem_write_data hold the last command values.
- Latency: req sampled in cycle N, memory accessed in N+1, ack in N+2. Peak throughput is one transaction per 3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack is seen; they are sampled only in IDLE.
  - Drop req in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- Losing requester: its req stays pending, and it is granted on the next IDLE because round-robin alternates.
- rdata and err hold their values until the next RESP overwrites them.
- Starvation-free: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.

Optional Feature:
- Macro DMEM_ARB_BOUNDS_CHK_EN.
- When defined:
  - In IDLE, a latched command is marked faulty if addr[1:0] != 0 or addr >= MEM_WORDS*4.
  - For a faulty command, ACCESS keeps mem_read = mem_write = 0, so memory is untouched.
  - RESP then issues ack with err = 1 and rdata = 0.
  - Non-faulty commands give err = 0.
- When undefined: no checking; err is tied to 0; every command reaches memory.

Test Plan:
- Reset, then req = 01, we = 01, addr0 = 0x10, wdata0 = 0xDEADBEEF -> mem_write high in cycle 2 only; ack = 01 in cycle 3; memory word 4 = 0xDEADBEEF.
- Load from requester 1 with addr1 = 0x10 -> mem_read high for one cycle; ack = 10 two cycles after req; rdata = 0xDEADBEEF.
- req = 11 held continuously, both loads -> ack sequence 01, 10, 01, 10 at 3-cycle spacing; requester 0 is served first after reset.
- Reset asserted during the ACCESS cycle of a store of 0x12345678 to 0x20 -> mem_write low at that edge; word 8 unchanged (0); no ack; FSM in IDLE.
- With DMEM_ARB_BOUNDS_CHK_EN: store to 0x4000 and load from 0x6 -> mem_write and mem_read never assert; ack with err = 1, rdata = 0. Without the macro, the same load gives err = 0.
- req held high through ack -> a second transaction starts in the following IDLE; ack again 3 cycles later.
